// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// Holds the FSM state encoding, the default operand width and a counter-width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Smallest bit count able to hold the values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_ripple_adder.sv
// Ripple-carry adder built from full_adder cells.
// This carry chain is shared with the subtractor, so its structure stays plain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = cin;
  assign cout       = w_carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (x[i]),
      .b    (y[i]),
      .cin  (w_carry[i]),
      .sum  (sum[i]),
      .cout (w_carry[i+1])
    );
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one conditional add and one right shift per cycle.
// Operands and product move over valid/ready handshakes.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = clog2(WIDTH);

  state_t             r_state;
  state_t             w_nextState;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [CW-1:0]      r_count;
  logic               r_outValid;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [WIDTH:0]     w_hiNext;
  logic [2*WIDTH-1:0] w_accNext;
  logic               w_lastStep;

  ripple_adder #(.WIDTH(WIDTH)) u_adder (
    .x    (r_acc[2*WIDTH-1:WIDTH]),
    .y    (r_mcand),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // The carry is shifted into the top bit so (2^W-1)^2 loses nothing.
  assign w_hiNext   = r_acc[0] ? {w_cout, w_sum} : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
  assign w_accNext  = {w_hiNext, r_acc[WIDTH-1:1]};
  assign w_lastStep = (r_count == CW'(WIDTH - 1));

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_outValid;
  assign product   = r_product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (in_valid)   w_nextState = RUN;
      RUN:     if (w_lastStep) w_nextState = DONE;
      DONE:    if (out_ready)  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_mcand    <= '0;
      r_count    <= '0;
      r_outValid <= 1'b0;
      r_product  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mcand <= a;
            r_acc   <= {{WIDTH{1'b0}}, b};
            r_count <= '0;
          end
        end
        RUN: begin
          r_acc   <= w_accNext;
          r_count <= r_count + 1'b1;
          if (w_lastStep) begin
            r_product  <= w_accNext;
            r_outValid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_outValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed cases then random operands,
// compared against plain a*b arithmetic.
module tb_shift_add_multiplier;

  localparam int W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             in_ready;
  logic             out_valid;
  logic [2*W-1:0]   product;

  int checks = 0;
  int failures = 0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] refProduct(input int x, input int y);
    return 32'(x * y);
  endfunction

  // One full transaction: accept, latency, optional backpressure, handshake.
  task automatic applyStimulus(input int aVal, input int bVal, input int stallCycles,
                               input bit holdInValid);
    logic [31:0] expected;
    int budget;
    expected = refProduct(aVal, bVal);
    budget = 0;
    while (!in_ready && budget < 50) begin
      tick();
      budget++;
    end
    checkOutput("in_ready_before_accept", 32'(in_ready), 1);
    a = W'(aVal);
    b = W'(bVal);
    in_valid = 1'b1;
    out_ready = (stallCycles == 0);
    tick();
    in_valid = 1'b0;
    a = '1;
    b = '1;
    checkOutput("in_ready_drop", 32'(in_ready), 0);
    for (int i = 1; i < W; i++) begin
      tick();
      checkOutput("busy_no_valid", 32'(out_valid), 0);
    end
    tick();
    checkOutput("out_valid_rise", 32'(out_valid), 1);
    checkOutput("product", 32'(product), expected);
    if (holdInValid) in_valid = 1'b1;
    for (int i = 0; i < stallCycles; i++) begin
      tick();
      checkOutput("stall_valid", 32'(out_valid), 1);
      checkOutput("stall_product", 32'(product), expected);
      checkOutput("stall_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("handshake_valid_low", 32'(out_valid), 0);
    checkOutput("handshake_in_ready", 32'(in_ready), 1);
    checkOutput("product_kept", 32'(product), expected);
    if (holdInValid) begin
      in_valid = 1'b0;
      tick();
      checkOutput("no_accept_in_done", 32'(in_ready), 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    checkOutput("reset_out_valid", 32'(out_valid), 0);
    checkOutput("reset_product", 32'(product), 0);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 1);

    applyStimulus(3, 5, 0, 1'b0);
    applyStimulus(15, 15, 0, 1'b0);
    applyStimulus(0, 9, 0, 1'b0);
    applyStimulus(9, 0, 0, 1'b0);
    applyStimulus(7, 6, 10, 1'b1);
    applyStimulus(5, 3, 0, 1'b0);

    // Reset two cycles into RUN must clear everything at once.
    a = W'(4);
    b = W'(4);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_valid", 32'(out_valid), 0);
    checkOutput("midrun_reset_product", 32'(product), 0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("after_reset_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < W + 2; i++) begin
      tick();
      checkOutput("no_pulse_after_reset", 32'(out_valid), 0);
    end
    applyStimulus(2, 2, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned multiplier built on the team's ripple-carry adder chain: one conditional add and one right shift per cycle.
- Addition-side counterpart of the 4-bit two's-complement subtractor; the two together complete the datapath arithmetic set.
- Operands enter and the product leaves over valid/ready handshakes, so the block sits between an operand source and a result sink in the datapath.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits; legal values 2..16.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair a, b is present.
- in_ready  output  1  block will accept an operand pair this cycle.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product is valid.
- out_ready  input  1  sink accepts the product this cycle.
- product  output  2*WIDTH  a*b, unsigned, exact (no overflow possible).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, step counter=0, accumulator=0, multiplicand register=0, out_valid=0, product=0. in_ready=1 once rst_n deasserts.
- FSM states are IDLE, RUN and DONE.
- in_ready = (state==IDLE), decoded combinationally from the state register. out_valid = (state==DONE), registered.
- IDLE:
  - On an edge where in_valid&&in_ready: latch a into the multiplicand register; acc[2W-1:W]=0, acc[W-1:0]=b; counter=0; go to RUN.
  - Without in_valid, stay in IDLE.
- RUN, once per cycle:
  - If acc[0]==1: {c, hi} = acc[2W-1:W] + mcand, a (W+1)-bit sum. Otherwise {c, hi} = {0, acc[2W-1:W]}.
  - Update acc <= {c, hi, acc[W-1:1]} (logical right shift by one with the carry shifted in).
  - counter++. On the edge where the counter reaches WIDTH-1, after its update go to DONE and drive product from the final acc.
- Latency: accept edge E; out_valid goes high after edge E+WIDTH (WIDTH RUN cycles).
- DONE:
  - product and out_valid are held stable while out_ready=0; backpressure may last indefinitely.
  - On an edge with out_ready=1: out_valid->0, go to IDLE.
  - product keeps its value until the next DONE.
- Minimum issue interval is WIDTH+2 cycles.
  - in_valid asserted in the same cycle as a DONE handshake is NOT accepted.
  - in_ready rises the cycle after the handshake.
- Inputs a/b/in_valid are ignored in RUN and DONE. Operand changes while busy must not affect the result.
- Operand boundaries: a=0 or b=0 gives product 0 after full latency, with no early exit. The maximum operands (2^W-1)^2 must give no lost carry; the carry bit is required for this.
- Reset asserted mid-RUN or in DONE: immediate return to the reset values. The partial result is discarded and no out_valid pulse appears.
- X-free: all registers are reset; there are no latches.

Decomposition:
- Shared package mult_pkg holds:
  - state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default WIDTH constant;
  - counter width function clog2(WIDTH).
- One sub-module, ripple_adder #(WIDTH): ports x, y, cin -> sum, cout.
  - Built from the existing full_adder cells.
  - Instantiated once with cin=0.
  - Shares its structure with the subtractor, so the adder carry chain is verified once.

Test Plan:
- Reset then a=3, b=5, out_ready=1 -> in_ready drops next cycle; out_valid high 4 cycles after accept; product=8'd15; back to IDLE one cycle later.
- a=15, b=15 -> product=8'd225 (0xE1). Checks the carry bit on the top add.
- a=0, b=9 and a=9, b=0 -> product=0 after full 4-cycle latency in both cases.
- a=7, b=6 with out_ready=0 for 10 cycles -> out_valid and product=42 stable throughout. Raise out_ready -> one handshake, then IDLE. in_valid held high during DONE is not accepted.
- Accept a=5, b=3, then change a/b to 15/15 during RUN -> product=15, unaffected.
- Pull rst_n low two cycles into RUN -> out_valid=0 and product=0 immediately (asynchronously). After release, in_ready=1 and a new operation a=2, b=2 gives product=4.
